// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: operation modes and FSM states.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Only the movement operations are meaningful to repeat as a burst.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational next-value function shared by the single-step and burst paths.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      MODE_LOAD: next_q = d;
      MODE_SHL:  next_q = {q[WIDTH-2:0], serial_in};
      MODE_SHR:  next_q = {serial_in, q[WIDTH-1:1]};
      MODE_ROTL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: next_q = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   next_q = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift/rotate register with single-step operation and a counted burst FSM.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = $clog2(WIDTH) + 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [2:0]       cap_mode;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] next_q;

  // During a burst the captured mode drives the step; otherwise the live mode does.
  assign step_mode = (state == ST_RUN) ? cap_mode : mode;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q         (q),
    .mode      (step_mode),
    .serial_in (serial_in),
    .d         (d),
    .next_q    (next_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RESET_VAL;
      state    <= ST_IDLE;
      count    <= '0;
      cap_mode <= MODE_HOLD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && is_burst_mode(mode)) begin
            cap_mode <= mode;
            count    <= amount;
            state    <= (amount == '0) ? ST_DONE : ST_RUN;
          end else if (enable) begin
            q <= next_q;
          end
        end
        ST_RUN: begin
          if (enable) begin
            q     <= next_q;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1))
              state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign q_bar  = ~q;
  assign so_msb = q[WIDTH-1];
  assign so_lsb = q[0];
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: expected values queued per edge, checked after it.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst, enable, serial_in, start;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [CW-1:0] amount;
  logic [W-1:0]  q, q_bar;
  logic          so_msb, so_lsb, busy, done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q_sb[$];
  logic         exp_busy_sb[$];
  logic         exp_done_sb[$];
  string        tag_sb[$];

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .d(d),
    .serial_in(serial_in), .start(start), .amount(amount),
    .q(q), .q_bar(q_bar), .so_msb(so_msb), .so_lsb(so_lsb),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the coming edge, then compare once the edge has passed.
  task automatic tick(input string tag, input logic [W-1:0] eq, input logic eb, input logic ed);
    logic [W-1:0] pq;
    string        t;
    exp_q_sb.push_back(eq);
    exp_busy_sb.push_back(eb);
    exp_done_sb.push_back(ed);
    tag_sb.push_back(tag);
    @(posedge clk);
    #1;
    pq = exp_q_sb.pop_front();
    t  = tag_sb.pop_front();
    check_vec({t, ".q"}, q, pq);
    check_vec({t, ".q_bar"}, q_bar, ~pq);
    check_bit({t, ".so_msb"}, so_msb, pq[W-1]);
    check_bit({t, ".so_lsb"}, so_lsb, pq[0]);
    check_bit({t, ".busy"}, busy, exp_busy_sb.pop_front());
    check_bit({t, ".done"}, done, exp_done_sb.pop_front());
  endtask

  initial begin
    logic [W-1:0] e;
    rst = 1'b1; enable = 1'b0; serial_in = 1'b0; start = 1'b0;
    mode = MODE_HOLD; d = '0; amount = '0;
    @(negedge clk);
    tick("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    mode = MODE_LOAD; d = 8'hA5; enable = 1'b1;
    tick("load", 8'hA5, 1'b0, 1'b0);
    enable = 1'b0; d = 8'hFF;
    tick("hold_en0", 8'hA5, 1'b0, 1'b0);

    mode = MODE_ROTL; start = 1'b1; amount = 4'd3; enable = 1'b1;
    tick("rotl_start", 8'hA5, 1'b1, 1'b0);
    start = 1'b0; mode = MODE_LOAD; d = 8'h00;
    tick("rotl_1", 8'h4B, 1'b1, 1'b0);
    tick("rotl_2", 8'h96, 1'b1, 1'b0);
    tick("rotl_3", 8'h2D, 1'b0, 1'b1);
    mode = MODE_HOLD;
    tick("rotl_idle", 8'h2D, 1'b0, 1'b0);

    mode = MODE_LOAD; d = 8'h96;
    tick("load96", 8'h96, 1'b0, 1'b0);
    mode = MODE_ASR;
    tick("asr_single", 8'hCB, 1'b0, 1'b0);

    mode = MODE_LOAD; d = 8'h00;
    tick("load00", 8'h00, 1'b0, 1'b0);
    mode = MODE_SHR; serial_in = 1'b1; start = 1'b1; amount = 4'd4;
    tick("shr_start", 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    tick("shr_1", 8'h80, 1'b1, 1'b0);
    tick("shr_2", 8'hC0, 1'b1, 1'b0);
    enable = 1'b0;
    tick("shr_pause1", 8'hC0, 1'b1, 1'b0);
    tick("shr_pause2", 8'hC0, 1'b1, 1'b0);
    enable = 1'b1;
    tick("shr_3", 8'hE0, 1'b1, 1'b0);
    tick("shr_4", 8'hF0, 1'b0, 1'b1);
    mode = MODE_HOLD; serial_in = 1'b0;
    tick("shr_idle", 8'hF0, 1'b0, 1'b0);

    mode = MODE_SHL; start = 1'b1; amount = 4'd0;
    tick("amt0_done", 8'hF0, 1'b0, 1'b1);
    start = 1'b0; mode = MODE_HOLD;
    tick("amt0_idle", 8'hF0, 1'b0, 1'b0);

    mode = MODE_ROTR; start = 1'b1; amount = 4'd2;
    tick("rotr_start", 8'hF0, 1'b1, 1'b0);
    mode = MODE_SHL; amount = 4'd5;
    tick("rotr_1_startign", 8'h78, 1'b1, 1'b0);
    tick("rotr_2", 8'h3C, 1'b0, 1'b1);
    tick("done_startign", 8'h3C, 1'b0, 1'b0);
    start = 1'b0; mode = MODE_HOLD;
    tick("rotr_idle", 8'h3C, 1'b0, 1'b0);

    mode = MODE_SHL; serial_in = 1'b0; start = 1'b1; amount = 4'd5;
    tick("abort_start", 8'h3C, 1'b1, 1'b0);
    start = 1'b0;
    tick("abort_1", 8'h78, 1'b1, 1'b0);
    rst = 1'b1;
    tick("abort_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; mode = MODE_HOLD;
    tick("abort_nodone1", 8'h00, 1'b0, 1'b0);
    tick("abort_nodone2", 8'h00, 1'b0, 1'b0);

    mode = MODE_LOAD; d = 8'h80;
    tick("load80", 8'h80, 1'b0, 1'b0);
    mode = MODE_ASR; start = 1'b1; amount = 4'd10;
    tick("asr_start", 8'h80, 1'b1, 1'b0);
    start = 1'b0; mode = MODE_HOLD;
    e = 8'h80;
    for (int i = 1; i <= 10; i++) begin
      e = {e[W-1], e[W-1:1]};
      tick($sformatf("asr_sat_%0d", i), e, (i < 10), (i == 10));
    end
    tick("asr_sat_idle", 8'hFF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
